// File: rtl/lock_pkg.sv
// Shared definitions for the door-lock controller: state encodings and width helpers.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'b000,
        ST_IDLE  = 3'b001,
        ST_OPEN  = 3'b100,
        ST_SETPW = 3'b101,
        ST_LOCK  = 3'b111
    } state_t;

    localparam int STATE_W            = 3;
    localparam int DEF_DIGITS         = 4;
    localparam int DEF_DIGIT_W        = 4;
    localparam int DEF_MAX_TRIES      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 8;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/door_lock_ctrl_if.sv
// Keypad-side pulses and display/actuator-side status of the door-lock controller.
interface door_lock_ctrl_if #(
    parameter int DIGIT_W = 4,
    parameter int FAIL_W  = 2,
    parameter int TIMER_W = 4
) ();
    logic               power_toggle;
    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic               star;
    logic               pw_change;
    logic [2:0]         state;
    logic               opened;
    logic               locked;
    logic [FAIL_W-1:0]  fail_count;
    logic [TIMER_W-1:0] lock_timer;

    modport master (
        output power_toggle, digit_valid, digit, star, pw_change,
        input  state, opened, locked, fail_count, lock_timer
    );

    modport slave (
        input  power_toggle, digit_valid, digit, star, pw_change,
        output state, opened, locked, fail_count, lock_timer
    );
endinterface

// File: rtl/digit_shift_buffer.sv
// Code entry shift register (newest digit in the LS position) with a saturating digit count.
module digit_shift_buffer
    import lock_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      shift_en,
    input  logic [DIGIT_W-1:0]        digit_in,
    output logic [DIGITS*DIGIT_W-1:0] buf_out,
    output logic                      full
);
    localparam int BUF_W = DIGITS * DIGIT_W;
    localparam int CNT_W = cnt_width(DIGITS);

    logic [BUF_W-1:0] buf_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else if (shift_en) begin
            // Oldest digit falls off the MS end.
            buf_q <= (buf_q << DIGIT_W) | BUF_W'(digit_in);
            if (cnt_q != CNT_W'(DIGITS))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign buf_out = buf_q;
    assign full    = (cnt_q == CNT_W'(DIGITS));
endmodule

// File: rtl/door_lock_ctrl.sv
// Keypad door-lock controller: FSM, stored password, failed-attempt counter and lockout timer.
module door_lock_ctrl
    import lock_pkg::*;
#(
    parameter int                                  DIGITS         = 4,
    parameter int                                  DIGIT_W        = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]           DEFAULT_PW     = 16'h1234,
    parameter int                                  MAX_TRIES      = 3,
    parameter int                                  LOCKOUT_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    door_lock_ctrl_if.slave  bus
);
    localparam int BUF_W   = DIGITS * DIGIT_W;
    localparam int FAIL_W  = cnt_width(MAX_TRIES);
    localparam int TIMER_W = cnt_width(LOCKOUT_CYCLES);

    state_t             state_q, state_d;
    logic [FAIL_W-1:0]  fail_q, fail_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [BUF_W-1:0]   pw_q, pw_d;
    logic               opened_q, locked_q;

    logic               buf_clear, buf_shift;
    logic [BUF_W-1:0]   entry_buf;
    logic               entry_full;

    digit_shift_buffer #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W)
    ) u_entry (
        .clk      (clk),
        .reset    (reset),
        .clear    (buf_clear),
        .shift_en (buf_shift),
        .digit_in (bus.digit),
        .buf_out  (entry_buf),
        .full     (entry_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_OFF;
            fail_q   <= '0;
            timer_q  <= '0;
            pw_q     <= DEFAULT_PW;
            opened_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
            pw_q     <= pw_d;
            opened_q <= (state_d == ST_OPEN);
            locked_q <= (state_d == ST_LOCK);
        end
    end

    // The if/else chains below encode input priority: power_toggle > star > pw_change > digit_valid.
    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        timer_d   = timer_q;
        pw_d      = pw_q;
        buf_clear = 1'b0;
        buf_shift = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (bus.power_toggle)
                    state_d = ST_IDLE;
            end

            ST_IDLE: begin
                if (bus.power_toggle) begin
                    state_d   = ST_OFF;
                    buf_clear = 1'b1;
                end else if (bus.star) begin
                    buf_clear = 1'b1;
                    if (entry_full && (entry_buf == pw_q)) begin
                        state_d = ST_OPEN;
                        fail_d  = '0;
                    end else begin
                        fail_d = fail_q + FAIL_W'(1);
                        if (fail_d == FAIL_W'(MAX_TRIES)) begin
                            state_d = ST_LOCK;
                            timer_d = TIMER_W'(LOCKOUT_CYCLES);
                        end
                    end
                end else if (!bus.pw_change && bus.digit_valid) begin
                    buf_shift = 1'b1;
                end
            end

            ST_OPEN: begin
                if (bus.power_toggle) begin
                    state_d   = ST_OFF;
                    buf_clear = 1'b1;
                end else if (bus.star) begin
                    state_d = ST_IDLE;
                end else if (bus.pw_change) begin
                    state_d   = ST_SETPW;
                    buf_clear = 1'b1;
                end
            end

            ST_SETPW: begin
                if (bus.power_toggle) begin
                    state_d   = ST_OFF;
                    buf_clear = 1'b1;
                end else if (bus.star) begin
                    buf_clear = 1'b1;
                    if (entry_full) begin
                        pw_d    = entry_buf;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_OPEN;
                    end
                end else if (!bus.pw_change && bus.digit_valid) begin
                    buf_shift = 1'b1;
                end
            end

            ST_LOCK: begin
                // Lockout ends on the edge that sees the timer at 1.
                if (timer_q <= TIMER_W'(1)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            default: begin
                state_d   = ST_OFF;
                buf_clear = 1'b1;
            end
        endcase
    end

    assign bus.state      = state_q;
    assign bus.opened     = opened_q;
    assign bus.locked     = locked_q;
    assign bus.fail_count = fail_q;
    assign bus.lock_timer = timer_q;
endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed bench for door_lock_ctrl with hand-computed expectations at the default parameters.
module tb_door_lock_ctrl;
    localparam logic [31:0] S_OFF   = 32'd0;
    localparam logic [31:0] S_IDLE  = 32'd1;
    localparam logic [31:0] S_OPEN  = 32'd4;
    localparam logic [31:0] S_SETPW = 32'd5;
    localparam logic [31:0] S_LOCK  = 32'd7;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    door_lock_ctrl_if #(.DIGIT_W(4), .FAIL_W(2), .TIMER_W(4)) bus ();

    door_lock_ctrl #(
        .DIGITS         (4),
        .DIGIT_W        (4),
        .DEFAULT_PW     (16'h1234),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: inputs applied at negedge, outputs settle just after the posedge.
    task automatic step(input logic pt, input logic dv, input logic [3:0] d,
                        input logic st, input logic pc);
        @(negedge clk);
        bus.power_toggle = pt;
        bus.digit_valid  = dv;
        bus.digit        = d;
        bus.star         = st;
        bus.pw_change    = pc;
        @(posedge clk);
        #1;
        bus.power_toggle = 1'b0;
        bus.digit_valid  = 1'b0;
        bus.digit        = 4'h0;
        bus.star         = 1'b0;
        bus.pw_change    = 1'b0;
    endtask

    task automatic nop();         step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0); endtask
    task automatic power();       step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0); endtask
    task automatic key(input logic [3:0] d); step(1'b0, 1'b1, d, 1'b0, 1'b0); endtask
    task automatic submit();      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0); endtask
    task automatic pwchg();       step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1); endtask

    task automatic code(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.power_toggle = 1'b0;
        bus.digit_valid  = 1'b0;
        bus.digit        = 4'h0;
        bus.star         = 1'b0;
        bus.pw_change    = 1'b0;
        repeat (2) @(posedge clk);

        // 1. Reset state, OFF ignores inputs, unlock with default code
        do_reset();
        chk("rst_state",  32'(bus.state),      S_OFF);
        chk("rst_opened", 32'(bus.opened),     32'd0);
        chk("rst_locked", 32'(bus.locked),     32'd0);
        chk("rst_fail",   32'(bus.fail_count), 32'd0);
        chk("rst_timer",  32'(bus.lock_timer), 32'd0);
        step(1'b0, 1'b1, 4'h1, 1'b1, 1'b1);
        chk("off_ignores", 32'(bus.state), S_OFF);
        power();
        chk("pwr_on", 32'(bus.state), S_IDLE);
        code(4'h1, 4'h2, 4'h3, 4'h4);
        submit();
        chk("t1_state",  32'(bus.state),      S_OPEN);
        chk("t1_opened", 32'(bus.opened),     32'd1);
        chk("t1_fail",   32'(bus.fail_count), 32'd0);

        // 2. Lockout after three wrong codes, 8 cycles in LOCK
        do_reset();
        power();
        code(4'h1, 4'h2, 4'h3, 4'h5); submit();
        chk("t2_fail1", 32'(bus.fail_count), 32'd1);
        chk("t2_idle1", 32'(bus.state),      S_IDLE);
        code(4'h1, 4'h2, 4'h3, 4'h5); submit();
        chk("t2_fail2", 32'(bus.fail_count), 32'd2);
        code(4'h1, 4'h2, 4'h3, 4'h5); submit();
        chk("t2_lock_state", 32'(bus.state),      S_LOCK);
        chk("t2_locked",     32'(bus.locked),     32'd1);
        chk("t2_timer8",     32'(bus.lock_timer), 32'd8);
        chk("t2_fail3",      32'(bus.fail_count), 32'd3);
        for (int i = 1; i <= 7; i++) begin
            if (i % 2 == 1) power();
            else            key(4'h1);
            chk("t2_in_lock", 32'(bus.state),      S_LOCK);
            chk("t2_countdn", 32'(bus.lock_timer), 32'(8 - i));
        end
        nop();
        chk("t2_exit_state",  32'(bus.state),      S_IDLE);
        chk("t2_exit_fail",   32'(bus.fail_count), 32'd0);
        chk("t2_exit_timer",  32'(bus.lock_timer), 32'd0);
        chk("t2_exit_locked", 32'(bus.locked),     32'd0);

        // 3. Password change to 9876
        do_reset();
        power();
        code(4'h1, 4'h2, 4'h3, 4'h4); submit();
        pwchg();
        chk("t3_setpw", 32'(bus.state),  S_SETPW);
        chk("t3_opened_setpw", 32'(bus.opened), 32'd0);
        code(4'h9, 4'h8, 4'h7, 4'h6); submit();
        chk("t3_commit", 32'(bus.state), S_IDLE);
        code(4'h1, 4'h2, 4'h3, 4'h4); submit();
        chk("t3_old_fails", 32'(bus.fail_count), 32'd1);
        chk("t3_old_idle",  32'(bus.state),      S_IDLE);
        code(4'h9, 4'h8, 4'h7, 4'h6); submit();
        chk("t3_new_opens", 32'(bus.state),      S_OPEN);
        chk("t3_new_fail0", 32'(bus.fail_count), 32'd0);

        // 4. Aborted change keeps 1234; overflow drops the oldest digit
        do_reset();
        power();
        code(4'h1, 4'h2, 4'h3, 4'h4); submit();
        pwchg();
        key(4'h9); key(4'h8); submit();
        chk("t4_abort_open", 32'(bus.state), S_OPEN);
        key(4'h7);
        chk("t4_open_ignores_digit", 32'(bus.state), S_OPEN);
        submit();
        chk("t4_relock", 32'(bus.state), S_IDLE);
        key(4'h5); code(4'h1, 4'h2, 4'h3, 4'h4); submit();
        chk("t4_overflow_opens", 32'(bus.state), S_OPEN);

        // 5. Priority and fail_count persistence across power cycling
        do_reset();
        power();
        code(4'h1, 4'h2, 4'h3, 4'h4);
        step(1'b0, 1'b1, 4'h5, 1'b1, 1'b0);
        chk("t5_star_wins", 32'(bus.state), S_OPEN);
        submit();
        key(4'h1); key(4'h2); key(4'h3);
        step(1'b0, 1'b1, 4'h4, 1'b1, 1'b0);
        chk("t5_short_fail", 32'(bus.fail_count), 32'd1);
        key(4'h1); key(4'h2); key(4'h3);
        step(1'b0, 1'b1, 4'h4, 1'b0, 1'b1);
        submit();
        chk("t5_pwchg_discards_digit", 32'(bus.fail_count), 32'd2);
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("t5_power_off", 32'(bus.state),      S_OFF);
        chk("t5_off_fail",  32'(bus.fail_count), 32'd2);
        power();
        chk("t5_on_state", 32'(bus.state),      S_IDLE);
        chk("t5_on_fail",  32'(bus.fail_count), 32'd2);

        // 6. Reset during LOCK and during SETPW
        do_reset();
        power();
        repeat (3) begin
            code(4'h0, 4'h0, 4'h0, 4'h0); submit();
        end
        repeat (3) nop();
        chk("t6_timer5", 32'(bus.lock_timer), 32'd5);
        do_reset();
        chk("t6_lock_rst_state", 32'(bus.state),      S_OFF);
        chk("t6_lock_rst_timer", 32'(bus.lock_timer), 32'd0);
        chk("t6_lock_rst_fail",  32'(bus.fail_count), 32'd0);
        chk("t6_lock_rst_lkd",   32'(bus.locked),     32'd0);
        power();
        code(4'h1, 4'h2, 4'h3, 4'h4); submit();
        pwchg();
        code(4'h9, 4'h8, 4'h7, 4'h6); submit();
        code(4'h9, 4'h8, 4'h7, 4'h6); submit();
        chk("t6_new_pw_open", 32'(bus.state), S_OPEN);
        pwchg();
        key(4'h5);
        do_reset();
        chk("t6_setpw_rst_state", 32'(bus.state), S_OFF);
        power();
        code(4'h1, 4'h2, 4'h3, 4'h4); submit();
        chk("t6_default_pw_back", 32'(bus.state), S_OPEN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
